// File: rtl/mnist_job_sched_if.sv
// ============================================================================
// Module   : mnist_job_sched_if
// Purpose  : Requester, accelerator and result signals of the MNIST job scheduler
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mnist_job_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [1:0]      img_sel;
  logic            accel_start;
  logic            accel_done;
  logic [3:0]      accel_digit;
  logic            accel_flush;
  logic            res_valid;
  logic            res_ready;
  logic [3:0]      res_digit;
  logic [1:0]      res_src;
  logic [15:0]     res_cycles;
  logic            res_timeout;
  logic            busy;
  logic [7:0]      timeout_cnt;

  // master: the scheduler itself; slave: requesters, accelerator and result sink
  modport master (
    input  req_valid, accel_done, accel_digit, res_ready,
    output req_ready, img_sel, accel_start, accel_flush, res_valid,
           res_digit, res_src, res_cycles, res_timeout, busy, timeout_cnt
  );
  modport slave (
    output req_valid, accel_done, accel_digit, res_ready,
    input  req_ready, img_sel, accel_start, accel_flush, res_valid,
           res_digit, res_src, res_cycles, res_timeout, busy, timeout_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mnist_job_sched.sv
// ============================================================================
// Module   : mnist_job_sched
// Purpose  : Round-robin job scheduler and watchdog for the shared MNIST core
// Revision : 1.0
// ============================================================================
`default_nettype none

module mnist_job_sched #(
  parameter int NREQ      = 2,
  parameter int TIMEOUT   = 2047,
  parameter int BLANK     = 2,
  parameter int FLUSH_LEN = 4
) (
  input wire                clk,
  input wire                rst,
  mnist_job_sched_if.master bus
);

  localparam int c_BLANK_W = (BLANK < 2) ? 1 : $clog2(BLANK + 1);
  localparam int c_FLUSH_W = (FLUSH_LEN < 2) ? 1 : $clog2(FLUSH_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_CAPT   = 3'd3,
    S_FLUSH  = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t               r_state, w_next;
  logic [1:0]           r_last, r_img_sel, w_win;
  logic                 w_found;
  logic [2:0]           w_cand;
  logic [3:0]           w_req4;
  logic [15:0]          r_cnt;
  logic [c_BLANK_W-1:0] r_blank;
  logic [c_FLUSH_W-1:0] r_flush;
  logic                 r_done_q;
  logic [3:0]           r_res_digit;
  logic [1:0]           r_res_src;
  logic [15:0]          r_res_cycles;
  logic                 r_res_timeout;
  logic [7:0]           r_tcnt;
  logic                 w_edge, w_tmo;
  logic [NREQ-1:0]      w_rdy;

  assign w_req4 = 4'(bus.req_valid);
  assign w_edge = bus.accel_done && !r_done_q && (r_blank == '0);
  assign w_tmo  = (r_cnt == 16'(TIMEOUT));

  // Round-robin: first requester after the previous winner, wrapping at NREQ
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_cand = {1'b0, r_last} + 3'(i);
      if (w_cand >= 3'(NREQ))
        w_cand = w_cand - 3'(NREQ);
      if (!w_found && w_req4[w_cand[1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rdy  = '0;
    case (r_state)
      S_IDLE:   if (w_found) w_next = S_START;
      S_START: begin
        w_next = S_WAIT;
        for (int i = 0; i < NREQ; i++)
          w_rdy[i] = (r_img_sel == 2'(i));
      end
      // A done edge beats a watchdog expiry in the same cycle
      S_WAIT: begin
        if (w_edge)
          w_next = S_CAPT;
        else if (w_tmo)
          w_next = S_FLUSH;
      end
      S_CAPT:   w_next = S_RESULT;
      S_FLUSH:  if (r_flush == '0) w_next = S_RESULT;
      S_RESULT: if (bus.res_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last        <= 2'(NREQ - 1);
      r_img_sel     <= '0;
      r_cnt         <= '0;
      r_blank       <= '0;
      r_flush       <= '0;
      r_done_q      <= 1'b1;
      r_res_digit   <= '0;
      r_res_src     <= '0;
      r_res_cycles  <= '0;
      r_res_timeout <= 1'b0;
      r_tcnt        <= '0;
    end else begin
      r_done_q <= bus.accel_done;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_last    <= w_win;
            r_img_sel <= w_win;
          end
        end
        S_START: begin
          r_cnt   <= 16'd1;
          r_blank <= c_BLANK_W'(BLANK);
        end
        S_WAIT: begin
          if (r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
          if (r_blank != '0)
            r_blank <= r_blank - 1'b1;
          if (w_edge) begin
            r_res_cycles <= r_cnt;
          end else if (w_tmo) begin
            r_res_digit   <= 4'hF;
            r_res_src     <= r_img_sel;
            r_res_cycles  <= 16'(TIMEOUT);
            r_res_timeout <= 1'b1;
            r_flush       <= c_FLUSH_W'(FLUSH_LEN - 1);
            if (r_tcnt != 8'hFF)
              r_tcnt <= r_tcnt + 8'd1;
          end
        end
        // argmax is latched by the core alongside done, so sample a cycle later
        S_CAPT: begin
          r_res_digit   <= bus.accel_digit;
          r_res_src     <= r_img_sel;
          r_res_timeout <= 1'b0;
        end
        S_FLUSH: begin
          if (r_flush != '0)
            r_flush <= r_flush - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = w_rdy;
  assign bus.img_sel     = r_img_sel;
  assign bus.accel_start = (r_state == S_START);
  assign bus.accel_flush = (r_state == S_FLUSH);
  assign bus.res_valid   = (r_state == S_RESULT);
  assign bus.res_digit   = r_res_digit;
  assign bus.res_src     = r_res_src;
  assign bus.res_cycles  = r_res_cycles;
  assign bus.res_timeout = r_res_timeout;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.timeout_cnt = r_tcnt;

endmodule

`default_nettype wire

// File: tb/tb_mnist_job_sched.sv
// ============================================================================
// Module   : tb_mnist_job_sched
// Purpose  : Randomized self-checking bench with a job-level reference model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mnist_job_sched;

  localparam int c_NREQ    = 2;
  localparam int c_TIMEOUT = 2047;
  localparam int c_BLANK   = 2;
  localparam int c_FLUSH   = 4;
  localparam int c_WD_TMO  = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_wd = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_last = c_NREQ - 1;
  int   m_tcnt = 0;
  bit   job_open = 1'b0;
  bit   wd_done = 1'b0;

  mnist_job_sched_if #(.NREQ(c_NREQ)) bus ();
  mnist_job_sched_if #(.NREQ(c_NREQ)) bus_wd ();

  mnist_job_sched #(.NREQ(c_NREQ), .TIMEOUT(c_TIMEOUT), .BLANK(c_BLANK), .FLUSH_LEN(c_FLUSH))
    dut (.clk(clk), .rst(rst), .bus(bus.master));

  // Short watchdog so counter saturation fits in a reasonable run
  mnist_job_sched #(.NREQ(c_NREQ), .TIMEOUT(c_WD_TMO), .BLANK(c_BLANK), .FLUSH_LEN(c_FLUSH))
    dut_wd (.clk(clk), .rst(rst_wd), .bus(bus_wd.master));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int rr_pick(input int last, input logic [1:0] req);
    for (int k = 1; k <= c_NREQ; k++)
      if (req[(last + k) % c_NREQ]) return (last + k) % c_NREQ;
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    chk("rdy_onehot", ($countones(bus.req_ready) <= 1), 1);
    chk("rdy_only_in_start", (bus.req_ready != 0), bus.accel_start);
    if (bus.accel_start) chk("start_while_busy", job_open, 0);
  endtask

  task automatic chk_zero();
    chk("rst_res", {bus.res_valid, bus.res_digit, bus.res_src, bus.res_cycles, bus.res_timeout}, 0);
    chk("rst_ctl", {bus.req_ready, bus.img_sel, bus.accel_start, bus.accel_flush,
                    bus.busy, bus.timeout_cnt}, 0);
  endtask

  task automatic chk_res(input logic [3:0] d, input int s, input int c, input bit t);
    chk("res_valid", bus.res_valid, 1);
    chk("res_digit", bus.res_digit, d);
    chk("res_src", bus.res_src, s);
    chk("res_cycles", bus.res_cycles, c);
    chk("res_timeout", bus.res_timeout, t);
    chk("timeout_cnt", bus.timeout_cnt, m_tcnt);
    chk("busy_result", bus.busy, 1);
  endtask

  // One job: lat = cycles from start to done rise (done never rises if beyond the watchdog)
  task automatic do_job(input logic [1:0] req, input int lat, input logic [3:0] dig,
                        input int hold, input int stale_drop, input int abort_at,
                        output int start_wait);
    int exp_w, res_k, flush_n, flush_k, exp_k;
    bit normal;
    exp_w = rr_pick(m_last, req);
    bus.req_valid = req;
    start_wait = -1;
    for (int w = 1; w <= 8; w++) begin
      step();
      if (bus.accel_start) begin start_wait = w; break; end
    end
    chk("start_seen", (start_wait > 0), 1);
    if (start_wait < 0) return;
    chk("grant_rdy", bus.req_ready, 32'd1 << exp_w);
    chk("grant_img_sel", bus.img_sel, exp_w);
    m_last = exp_w;
    job_open = 1'b1;
    if (stale_drop == 0) bus.accel_done = 1'b0;
    normal = (lat >= c_BLANK + 1) && (lat <= c_TIMEOUT);
    res_k = -1; flush_n = 0; flush_k = -1;
    for (int k = 1; k <= c_TIMEOUT + 20; k++) begin
      step();
      if (bus.accel_flush) begin
        if (flush_k < 0) flush_k = k;
        flush_n++;
      end
      if (bus.res_valid) begin res_k = k; break; end
      if (k == lat) begin bus.accel_done = 1'b1; bus.accel_digit = dig; end
      if (k == stale_drop) bus.accel_done = 1'b0;
      if (k == abort_at) begin
        bus.req_valid = '0;
        rst = 1'b0;
        #1;
        chk_zero();
        step();
        rst = 1'b1;
        m_last = c_NREQ - 1;
        m_tcnt = 0;
        job_open = 1'b0;
        repeat (5) begin
          step();
          chk("post_rst_no_res", {bus.res_valid, bus.busy}, 0);
        end
        return;
      end
    end
    if (!normal && m_tcnt < 255) m_tcnt++;
    exp_k = normal ? lat + 2 : c_TIMEOUT + c_FLUSH + 1;
    chk("res_at_cycle", res_k, exp_k);
    chk("flush_len", flush_n, normal ? 0 : c_FLUSH);
    if (!normal) chk("flush_at_cycle", flush_k, c_TIMEOUT + 1);
    if (res_k < 0) return;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) step();
      chk_res(normal ? dig : 4'hF, exp_w, normal ? lat : c_TIMEOUT, !normal);
    end
    bus.res_ready = 1'b1;
    step();
    job_open = 1'b0;
    chk("res_valid_drop", bus.res_valid, 0);
    chk("idle_not_busy", bus.busy, 0);
    bus.res_ready = 1'b0;
  endtask

  initial begin : main
    int sw, lat;
    logic [1:0] req;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    bus.accel_done = 1'b1;
    bus.accel_digit = 4'd0;
    repeat (2) @(negedge clk);
    chk_zero();
    rst = 1'b1;
    repeat (4) begin
      step();
      chk("idle_no_start", {bus.accel_start, bus.busy, bus.res_valid}, 0);
    end
    do_job(2'b01, 40, 4'd3, 0, 10, 0, sw);          // stale done high since reset
    do_job(2'b01, 830, 4'd6, 1, 0, 0, sw);          // nominal inference
    do_job(2'b01, 100000, 4'd0, 2, 0, 0, sw);       // watchdog
    do_job(2'b01, c_TIMEOUT, 4'd9, 0, 0, 0, sw);    // done exactly at watchdog limit
    do_job(2'b01, c_BLANK + 1, 4'd4, 0, 0, 0, sw);  // first cycle after blanking
    do_job(2'b01, c_BLANK, 4'd5, 0, 0, 0, sw);      // edge lost in blank window
    do_job(2'b10, 20, 4'd7, 100, 0, 0, sw);         // backpressure
    do_job(2'b10, 15, 4'd2, 0, 0, 0, sw);
    chk("start_after_handshake", sw, 1);
    do_job(2'b11, 100000, 4'd0, 0, 0, 300, sw);     // mid-job reset
    for (int j = 0; j < 3; j++) do_job(2'b11, 50, 4'(j + 1), 0, 0, 0, sw);
    for (int j = 0; j < 40; j++) begin
      req = 2'($urandom_range(1, 3));
      lat = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : int'($urandom_range(3, 120));
      do_job(req, lat, 4'($urandom_range(0, 9)), int'($urandom_range(0, 4)), 0, 0, sw);
    end
    bus.req_valid = '0;
    for (int i = 0; i < 30000 && !wd_done; i++) @(negedge clk);
    chk("wd_finished", wd_done, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : wd
    int n;
    n = 0;
    bus_wd.req_valid = 2'b01;
    bus_wd.res_ready = 1'b1;
    bus_wd.accel_done = 1'b0;
    bus_wd.accel_digit = 4'd0;
    repeat (2) @(negedge clk);
    rst_wd = 1'b1;
    for (int c = 0; c < 260 * 60 && n < 260; c++) begin
      @(negedge clk);
      if (bus_wd.res_valid) begin
        n++;
        chk("wd_tcnt", bus_wd.timeout_cnt, (n > 255) ? 255 : n);
        chk("wd_digit", bus_wd.res_digit, 4'hF);
        chk("wd_timeout", bus_wd.res_timeout, 1);
        chk("wd_cycles", bus_wd.res_cycles, c_WD_TMO);
      end
    end
    chk("wd_result_count", n, 260);
    wd_done = 1'b1;
  end

endmodule

`default_nettype wire

// File: doc/mnist_job_sched.md
Name: mnist_job_sched

Overview:
- Sequences the MNIST accelerator core and shares it between up to 4 image requesters (e.g. host loader, test-image ROM, self-test).
- Arbitrates round-robin, steers the image mux, pulses start, and detects the done rising edge.
- Captures the predicted digit with source tag and latency, and enforces a watchdog that flushes a hung accelerator.
- Sits between the requesters and the accelerator top, above the accelerator's internal control FSM.

Parameters:
NREQ, 2, number of requesters (2..4)
TIMEOUT, 2047, WAIT cycles before abort (nominal inference is about 830 cycles)
BLANK, 2, cycles after start during which accel_done is ignored
FLUSH_LEN, 4, cycles accel_flush is held high on abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester job request; level, held until accepted
req_ready  out  NREQ  one-hot, 1-cycle accept pulse to the granted requester
img_sel  out  2  index of the granted requester; drives the image-source mux
accel_start  out  1  1-cycle start pulse to the accelerator
accel_done  in  1  accelerator done; level, may stay high between jobs
accel_digit  in  4  accelerator predicted digit
accel_flush  out  1  synchronous reset to the accelerator on abort
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_digit  out  4  predicted digit; 4'hF on timeout
res_src  out  2  requester index of the result
res_cycles  out  16  cycles from accel_start to done edge; saturates at 16'hFFFF
res_timeout  out  1  result came from a watchdog abort
busy  out  1  high in every state except IDLE
timeout_cnt  out  8  total aborts; saturates at 255

Behaviour:
- Reset (rst low, asynchronous): state IDLE and all outputs 0. Round-robin pointer last=NREQ-1, so requester 0 wins first. Internal done_q=1, so a done that is high at reset is not taken as an edge. Asserting reset mid-job abandons the job silently: no result, no counter change.
- States: IDLE, START, WAIT, CAPT, FLUSH, RESULT.
- IDLE: if any req_valid is high, pick the first set bit searching from last+1 with wrap; update last to the winner; go to START.
- IDLE, no request: remain in IDLE. A requester that drops req_valid before grant is never acknowledged.
- START (exactly 1 cycle):
  - accel_start=1 and req_ready[winner]=1.
  - img_sel=winner, held stable from START through CAPT.
  - Cycle counter cleared to 1; blank counter loaded with BLANK.
  - Next state WAIT.
- WAIT:
  - Cycle counter increments each cycle, saturating at 16'hFFFF.
  - Blank counter decrements to 0.
  - done_q registers accel_done every cycle, in every state.
  - Done edge is accel_done && !done_q && blank==0. On a done edge: record the counter into res_cycles and go to CAPT.
  - A done edge that falls inside the blank window is lost. The job then ends by timeout, which is the required behaviour.
- CAPT (1 cycle):
  - Latch res_digit=accel_digit, res_src=img_sel, res_timeout=0.
  - Go to RESULT.
  - The digit is sampled one cycle after the edge because the accelerator latches argmax alongside done.
- Timeout: in WAIT, when the counter equals TIMEOUT with no done edge, go to FLUSH.
  - res_digit=4'hF, res_timeout=1, res_cycles=TIMEOUT.
  - timeout_cnt increments, saturating.
- Simultaneous done edge and timeout: the done edge wins.
- FLUSH: accel_flush=1 for FLUSH_LEN cycles, then go to RESULT.
- RESULT:
  - res_valid=1; all res_* fields held stable until res_valid && res_ready.
  - On the handshake, res_valid falls the next cycle and the state returns to IDLE.
  - New arbitration happens no earlier than the IDLE cycle, so the minimum gap between accel_start pulses is job length + 3 cycles.
  - req_valid changes while in RESULT are ignored.
- Timing rules:
  - req_ready is never asserted outside START.
  - accel_start is never asserted while busy with a prior job.
  - At most one req_ready bit is ever high.

Test Plan:
- Single job: req_valid=01, accel_done rises 830 cycles after start with accel_digit=6 -> one req_ready[0] pulse, one accel_start pulse; res_valid with digit 6, src 0, cycles 830, timeout 0.
- Round-robin: req_valid=11 held for 3 jobs, done after 50 cycles each -> grant order 0,1,0; img_sel matches each grant; res_src sequence 0,1,0.
- Stale done: accel_done already high at reset and left high, then start issued -> no spurious result. done is dropped at cycle 10 and raised at cycle 40 -> res_cycles=40.
- Watchdog: accel_done held low -> at cycle 2047 accel_flush high for 4 cycles; res_digit=F, res_timeout=1, timeout_cnt=1. Repeat 260 times -> timeout_cnt=255.
- Backpressure: res_ready low for 100 cycles while req_valid=10 -> result fields stable, no req_ready, no accel_start. res_ready pulse -> next START begins 2 cycles later.
- Mid-job reset: rst low for 1 cycle at WAIT cycle 300 -> all outputs 0 immediately; a next request is granted to requester 0 with no stale result.
